// File: rtl/cellrv32_npu_activation_control_if.sv
// Instruction and read/write handshake bundle for the NPU activation controller.
// The master side drives instructions; the slave side is the controller.
interface cellrv32_npu_activation_control_if #(
  parameter int ACC_ADDR_W  = 10,
  parameter int BUFF_ADDR_W = 12,
  parameter int LEN_W       = 10
);

  typedef struct packed {
    logic [ACC_ADDR_W-1:0]  acc_addr;
    logic [BUFF_ADDR_W-1:0] buff_addr;
    logic [LEN_W-1:0]       calc_len;
    logic [4:0]             opcode;
  } instruction_t;

  instruction_t           inst_i;
  logic                   inst_en_i;
  logic [ACC_ADDR_W-1:0]  acc_addr_o;
  logic                   acc_read_en_o;
  logic [3:0]             act_func_o;
  logic                   act_signed_o;
  logic [BUFF_ADDR_W-1:0] buff_addr_o;
  logic                   buff_write_en_o;
  logic                   busy_o;
  logic                   resource_busy_o;

  modport master (
    output inst_i, inst_en_i,
    input  acc_addr_o, acc_read_en_o, act_func_o, act_signed_o,
           buff_addr_o, buff_write_en_o, busy_o, resource_busy_o
  );

  modport slave (
    input  inst_i, inst_en_i,
    output acc_addr_o, acc_read_en_o, act_func_o, act_signed_o,
           buff_addr_o, buff_write_en_o, busy_o, resource_busy_o
  );

endinterface

// File: rtl/cellrv32_npu_activation_control.sv
// NPU activation controller: issues accumulator reads and the delayed unified-buffer writes.
// Optional feature macro: NPU_ACT_RELU6_EN (pass function code 2 through as ReLU6).
module cellrv32_npu_activation_control #(
  parameter int MATRIX_WIDTH = 14,
  parameter int ACT_LATENCY  = 3,
  parameter int ACC_ADDR_W   = 10,
  parameter int BUFF_ADDR_W  = 12,
  parameter int LEN_W        = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  cellrv32_npu_activation_control_if.slave bus
);

  if (ACT_LATENCY < 1 || ACT_LATENCY > 8 || MATRIX_WIDTH < 1) begin : g_param_check
    $error("cellrv32_npu_activation_control: ACT_LATENCY must be 1..8 and MATRIX_WIDTH positive");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [ACC_ADDR_W-1:0]  acc_addr_q;
  logic [BUFF_ADDR_W-1:0] buff_addr_q;
  logic [LEN_W-1:0]       cnt_q;
  logic [3:0]             func_q;
  logic                   signed_q;
  logic                   rd;

  logic [ACT_LATENCY:0]   vld_p;
  logic [3:0]             func_p0;
  logic                   sign_p0;
  logic [BUFF_ADDR_W-1:0] baddr_p [0:ACT_LATENCY];

  // Unsupported codes collapse to "none" so the activation unit never sees them.
  function automatic logic [3:0] map_func(input logic [3:0] code);
    logic [3:0] f;
    f = 4'd0;
    case (code)
      4'd1: f = 4'd1;
`ifdef NPU_ACT_RELU6_EN
      4'd2: f = 4'd2;
`else
      4'd2: f = 4'd0;
`endif
      default: f = 4'd0;
    endcase
    return f;
  endfunction

  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.inst_en_i) state_d = RUN;
      end
      RUN: begin
        rd = (cnt_q != '0);
        if (cnt_q <= LEN_W'(1)) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else if (enable_i) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_addr_q  <= '0;
      buff_addr_q <= '0;
      cnt_q       <= '0;
      func_q      <= '0;
      signed_q    <= 1'b0;
    end else if (enable_i) begin
      if (state_q == IDLE && bus.inst_en_i) begin
        acc_addr_q  <= bus.inst_i.acc_addr;
        buff_addr_q <= bus.inst_i.buff_addr;
        cnt_q       <= bus.inst_i.calc_len;
        func_q      <= map_func(bus.inst_i.opcode[3:0]);
        signed_q    <= bus.inst_i.opcode[4];
      end else if (rd) begin
        acc_addr_q  <= acc_addr_q + ACC_ADDR_W'(1);
        buff_addr_q <= buff_addr_q + BUFF_ADDR_W'(1);
        cnt_q       <= cnt_q - LEN_W'(1);
      end
    end
  end

  // Stage p0: accumulator read latency; stages p1..pN: activation datapath latency.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p <= '0;
    end else if (enable_i) begin
      vld_p <= {vld_p[ACT_LATENCY-1:0], rd};
    end
  end

  always_ff @(posedge clk_i) begin
    if (enable_i) begin
      func_p0    <= func_q;
      sign_p0    <= signed_q;
      baddr_p[0] <= buff_addr_q;
      for (int i = 1; i <= ACT_LATENCY; i++) begin
        baddr_p[i] <= baddr_p[i-1];
      end
    end
  end

  assign bus.acc_read_en_o   = rd;
  assign bus.acc_addr_o      = rd ? acc_addr_q : '0;
  assign bus.act_func_o      = vld_p[0] ? func_p0 : 4'd0;
  assign bus.act_signed_o    = vld_p[0] & sign_p0;
  assign bus.buff_write_en_o = vld_p[ACT_LATENCY];
  assign bus.buff_addr_o     = vld_p[ACT_LATENCY] ? baddr_p[ACT_LATENCY] : '0;
  assign bus.busy_o          = (state_q == RUN);
  assign bus.resource_busy_o = (state_q == RUN) | (|vld_p);

endmodule

// File: tb/tb_cellrv32_npu_activation_control.sv
// Bench for cellrv32_npu_activation_control: directed steps plus random traffic against
// a cycle-indexed schedule of expected reads, activations, writes and busy flags.
module tb_cellrv32_npu_activation_control;

  localparam int ACT_LATENCY = 3;
  localparam int ACC_ADDR_W  = 10;
  localparam int BUFF_ADDR_W = 12;
  localparam int LEN_W       = 10;
  localparam int ASZ         = 1 << ACC_ADDR_W;
  localparam int BSZ         = 1 << BUFF_ADDR_W;

  logic clk_i    = 1'b0;
  logic rst_i    = 1'b1;
  logic enable_i = 1'b0;

  cellrv32_npu_activation_control_if #(
    .ACC_ADDR_W (ACC_ADDR_W),
    .BUFF_ADDR_W(BUFF_ADDR_W),
    .LEN_W      (LEN_W)
  ) bus ();

  cellrv32_npu_activation_control #(
    .MATRIX_WIDTH(14),
    .ACT_LATENCY (ACT_LATENCY),
    .ACC_ADDR_W  (ACC_ADDR_W),
    .BUFF_ADDR_W (BUFF_ADDR_W),
    .LEN_W       (LEN_W)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .enable_i(enable_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Expected behaviour keyed by enabled-cycle index.
  int rd_m[int];
  int act_m[int];
  int wr_m[int];
  bit busy_m[int];
  bit infl_m[int];

  function automatic int exp_func(input logic [3:0] code);
    if (code == 4'd1) return 1;
`ifdef NPU_ACT_RELU6_EN
    if (code == 4'd2) return 2;
`endif
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic check_all(input string ctx);
    logic [31:0] e_rd, e_ra, e_fn, e_sg, e_wr, e_wa, e_bz, e_rb;
    e_rd = 0; e_ra = 0; e_fn = 0; e_sg = 0; e_wr = 0; e_wa = 0; e_bz = 0; e_rb = 0;
    if (rd_m.exists(cyc)) begin
      e_rd = 1;
      e_ra = rd_m[cyc];
    end
    if (act_m.exists(cyc)) begin
      e_fn = act_m[cyc] % 16;
      e_sg = act_m[cyc] / 16;
    end
    if (wr_m.exists(cyc)) begin
      e_wr = 1;
      e_wa = wr_m[cyc];
    end
    if (busy_m.exists(cyc)) e_bz = 1;
    if (busy_m.exists(cyc) || infl_m.exists(cyc)) e_rb = 1;
    check({ctx, "/acc_read_en"},   32'(bus.acc_read_en_o),   e_rd);
    check({ctx, "/acc_addr"},      32'(bus.acc_addr_o),      e_ra);
    check({ctx, "/act_func"},      32'(bus.act_func_o),      e_fn);
    check({ctx, "/act_signed"},    32'(bus.act_signed_o),    e_sg);
    check({ctx, "/buff_write_en"}, 32'(bus.buff_write_en_o), e_wr);
    check({ctx, "/buff_addr"},     32'(bus.buff_addr_o),     e_wa);
    check({ctx, "/busy"},          32'(bus.busy_o),          e_bz);
    check({ctx, "/resource_busy"}, 32'(bus.resource_busy_o), e_rb);
  endtask

  // An accepted instruction of length N issues reads in the N cycles after acceptance.
  task automatic model_edge(input bit en, input bit ie, input int aa, input int ba,
                            input int len, input logic [4:0] op);
    int k;
    if (!en) return;
    if (ie && !busy_m.exists(cyc)) begin
      for (int j = 0; j < len; j++) begin
        k = cyc + 1 + j;
        rd_m[k]  = (aa + j) % ASZ;
        act_m[k + 1] = exp_func(op[3:0]) + (op[4] ? 16 : 0);
        wr_m[k + 1 + ACT_LATENCY] = (ba + j) % BSZ;
        for (int d = 1; d <= ACT_LATENCY + 1; d++) infl_m[k + d] = 1'b1;
      end
      for (int j = 1; j <= ((len == 0) ? 1 : len); j++) busy_m[cyc + j] = 1'b1;
    end
    cyc++;
  endtask

  task automatic step(input bit en, input bit ie, input int aa, input int ba,
                      input int len, input logic [4:0] op, input string ctx);
    enable_i                = en;
    bus.inst_en_i           = ie;
    bus.inst_i.acc_addr     = aa[ACC_ADDR_W-1:0];
    bus.inst_i.buff_addr    = ba[BUFF_ADDR_W-1:0];
    bus.inst_i.calc_len     = len[LEN_W-1:0];
    bus.inst_i.opcode       = op;
    @(posedge clk_i);
    model_edge(en, ie, aa, ba, len, op);
    #1;
    check_all(ctx);
  endtask

  task automatic idle(input int n, input string ctx);
    repeat (n) step(1'b1, 1'b0, 0, 0, 0, 5'h00, ctx);
  endtask

  task automatic pulse_reset(input string ctx);
    bus.inst_en_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    rd_m.delete(); act_m.delete(); wr_m.delete(); busy_m.delete(); infl_m.delete();
    check_all({ctx, "/async"});
    @(posedge clk_i);
    #1;
    check_all({ctx, "/held"});
    rst_i = 1'b0;
  endtask

  initial begin
    int aa, ba, len;
    logic [4:0] op;
    bit en, ie;
    bus.inst_i    = '0;
    bus.inst_en_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_all("reset");
    rst_i = 1'b0;

    step(1'b1, 1'b1, 5, 20, 4, 5'h11, "basic");
    idle(10, "basic");

    step(1'b1, 1'b1, ASZ - 2, BSZ - 1, 4, 5'h01, "wrap");
    idle(9, "wrap");

    step(1'b1, 1'b1, 100, 7, 0, 5'h01, "len0");
    idle(6, "len0");

    step(1'b1, 1'b1, 30, 40, 6, 5'h11, "stall");
    idle(2, "stall");
    repeat (3) step(1'b0, 1'b1, 77, 77, 3, 5'h01, "stall_frozen");
    idle(12, "stall");

    step(1'b1, 1'b1, 200, 300, 3, 5'h11, "b2b_a");
    repeat (3) step(1'b1, 1'b1, 900, 900, 2, 5'h01, "b2b_drop");
    step(1'b1, 1'b1, 210, 303, 3, 5'h01, "b2b_b");
    idle(10, "b2b");

    step(1'b1, 1'b1, 50, 60, 6, 5'h11, "rst_run");
    idle(3, "rst_run");
    pulse_reset("rst_run");
    idle(10, "post_rst");

    step(1'b1, 1'b1, 10, 10, 2, 5'h02, "relu6");
    idle(8, "relu6");

    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      ie  = ($urandom_range(0, 2) == 0);
      aa  = ($urandom_range(0, 3) == 0) ? (ASZ - 1 - $urandom_range(0, 3)) : $urandom_range(0, ASZ - 1);
      ba  = ($urandom_range(0, 3) == 0) ? (BSZ - 1 - $urandom_range(0, 3)) : $urandom_range(0, BSZ - 1);
      len = $urandom_range(0, 6);
      op  = 5'($urandom_range(0, 31));
      step(en, ie, aa, ba, len, op, "random");
    end
    idle(12, "drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
